op_collector: RTL and testbench
===============================

// Module: op_collector
// PURPOSE
//  Parametrised operand collector between the vector register-file read ports and the issue/execute stage.
//  - Per lane group, it gathers DPG data operands and one mask operand that may arrive in different cycles
//    (bank conflicts).
//  - Each complete operand set is queued in a DEPTH-entry per-group FIFO.
//  - Sets are handed downstream over an independent valid/ready handshake per group.
//  - Adds to the single-slot buffer: multi-entry queueing, backpressure, flush, protocol-error flagging.
// PARAMETERS
//  NGROUPS  2    number of lane groups; each group has its own collector slot and FIFO
//  DPG      2    data operands per group; total data ports = NGROUPS*DPG
//  DEPTH    2    completed-set FIFO entries per group; must be >= 1
//  DATA_W   512  width of one data operand; default = $bits(vreg_t)
//  MASK_W   32   width of one mask operand; default = $bits(vmask_t)
//  CNT_W    $clog2(DEPTH+1)  width of the occupancy counter (localparam)
// PORTS
//  CLK          in   1                   clock, rising edge
//  nRST         in   1                   reset; asynchronous assert, active-low
//  flush_i      in   1                   drop all partial and queued sets in every group
//  dvalid_i     in   NGROUPS*DPG         data operand valid; port p belongs to group p/DPG
//  vreg_i       in   NGROUPS*DPG*DATA_W  data operands
//  mvalid_i     in   NGROUPS             mask operand valid, one per group
//  vmask_i      in   NGROUPS*MASK_W      mask operands
//  in_ready_o   out  NGROUPS             group accepts operand captures this cycle
//  out_valid_o  out  NGROUPS             complete set available
//  out_ready_i  in   NGROUPS             consumer takes the set
//  out_vreg_o   out  NGROUPS*DPG*DATA_W  head set, data operands
//  out_vmask_o  out  NGROUPS*MASK_W      head set, mask operand
//  count_o      out  NGROUPS*CNT_W       per-group FIFO occupancy
//  err_o        out  NGROUPS             sticky protocol-error flag
// BEHAVIOUR
//  Reset values
//  - Asynchronous clear of: slots, capture bits, FIFOs, counts and err.
//  - Outputs after reset: out_valid_o=0, out_vreg_o=0, out_vmask_o=0, count_o=0, err_o=0, in_ready_o=all 1.
//  Capture
//  - Per group: a capture-bit vector cap[DPG:0] (DPG data bits + 1 mask bit) plus a data holding slot.
//  - Operand captured when its valid is high and in_ready_o[g]=1; valid is ignored when in_ready_o[g]=0.
//  - in_ready_o[g] = (count[g] < DEPTH). Registered-derived; no combinational path from out_ready_i.
//  Completion
//  - Occurs in the cycle where (cap | incoming valids) becomes all ones.
//  - Set = slot contents, with same-cycle arrivals taking the incoming value.
//  - At that edge the set is pushed into the FIFO and cap is cleared.
//  - All operands in one cycle with cap=0 is a legal 1-cycle completion.
//  Errors and simultaneous events
//  - Duplicate capture (valid on a port whose cap bit is already set): new value overwrites and err_o[g] sets.
//    err_o[g] clears only on nRST.
//  - Pop: out_valid_o[g] & out_ready_i[g]. Push and pop in the same cycle leave count unchanged.
//  - FIFO is a circular buffer; read/write pointers wrap modulo DEPTH.
//  Latency
//  - Completion at cycle t -> out_valid_o at t+1.
//  - Output is the FIFO head, held stable while out_valid_o=1 and out_ready_i=0.
//  flush_i (synchronous)
//  - Next edge: cap, pointers and count cleared; captures in the flush cycle are discarded.
//  - err_o is not cleared.
//  - out_valid_o is low from the next cycle.
//  Groups are fully independent; no cross-group ordering.
//  Reset mid-operation: all in-flight sets are lost; no output toggles other than to the reset values.
// CONFIGURATION
//  OPC_BYPASS_EN defined:
//  - Bypass condition: group FIFO empty, completion this cycle, and no flush. Then out_valid_o[g]=1 in the
//    same cycle, with the set driven combinationally.
//  - If out_ready_i[g]=1 the set is consumed and not pushed; otherwise it is pushed as normal.
//  - Latency 0.
//  OPC_BYPASS_EN undefined:
//  - Latency 1 as above.
//  - All outputs are driven from flops only.
// STRUCTURE
//  vector_pkg additions:
//  - OPC_DPG constant.
//  - opset_t typedef: struct { vreg_t [OPC_DPG-1:0] vreg; vmask_t vmask; }.
//  - opc_cnt_t counter typedef.
//  Sub-module op_group_collector, generated NGROUPS times:
//  - Contents: cap bits, holding slot, FIFO, counter, err, and the bypass mux.
//  - Top level only slices the port vectors and fans out flush_i.
// TESTING
//  1 Aligned: g0 ports 0,1 and mask valid at t=5 with data A,B,M -> out_valid_o[0]=1 at t=6 carrying A,B,M;
//    count 1->0 on pop.
//  2 Conflict: port0=A at t=2, mask=M at t=3, port1=B at t=4 -> valid at t=5 with A,B,M; out_valid_o=0
//    before t=5.
//  3 Backpressure: DEPTH=2, out_ready=0, three complete sets issued
//    -> count=2, in_ready_o=0, third set's operands ignored.
//    Then raise out_ready -> sets 1,2 drain in order; in_ready returns to 1.
//  4 Duplicate: port0=A at t=1, port0=C at t=2, then port1 and mask -> set carries C; err_o[0]=1 and
//    stays 1 through later sets.
//  5 Flush: partial g1 set plus 1 queued g0 set, flush_i at t=10 -> count_o=0 and out_valid_o=0 at t=11;
//    err_o unchanged.
//  6 Bypass (OPC_BYPASS_EN): empty FIFO, all operands at t=3, out_ready=1 -> out_valid_o=1 at t=3, count
//    stays 0. Without macro -> valid at t=4.

Source files
------------

// File: rtl/op_collector_pkg.sv
// op_collector_pkg: operand/mask types and default sizes shared by the operand collector files
package op_collector_pkg;
   localparam int OPC_DPG   = 2;
   localparam int OPC_DEPTH = 2;
   typedef logic [511:0] vreg_t;
   typedef logic [31:0]  vmask_t;
   typedef struct packed {
      vreg_t [OPC_DPG-1:0] vreg;
      vmask_t              vmask;
   } opset_t;
   typedef logic [$clog2(OPC_DEPTH+1)-1:0] opc_cnt_t;
endpackage

// File: rtl/op_group_collector.sv
// op_group_collector: one lane group's capture slot, completed-set FIFO and output handshake
//   CLK/nRST            clock, async active-low reset
//   flush               drop partial and queued sets (err kept)
//   dvalid/vreg         DPG data operand captures
//   mvalid/vmask        mask operand capture
//   in_ready            FIFO not full, captures accepted
//   out_valid/out_ready head-set handshake; out_vreg/out_vmask carry the head set
//   count               FIFO occupancy; err sticky duplicate-capture flag
//   OPC_BYPASS_EN       when defined, a set completing into an empty FIFO is presented in the same cycle
module op_group_collector
   import op_collector_pkg::*;
#(
   parameter int DPG    = OPC_DPG,
   parameter int DEPTH  = OPC_DEPTH,
   parameter int DATA_W = $bits(vreg_t),
   parameter int MASK_W = $bits(vmask_t),
   parameter int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  flush,
   input  logic [DPG-1:0]        dvalid,
   input  logic [DPG*DATA_W-1:0] vreg,
   input  logic                  mvalid,
   input  logic [MASK_W-1:0]     vmask,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DPG*DATA_W-1:0] out_vreg,
   output logic [MASK_W-1:0]     out_vmask,
   output logic [CNT_W-1:0]      count,
   output logic                  err
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [DPG:0]                  cap, vin;
   logic [DPG*DATA_W-1:0]         slot_d, set_d;
   logic [MASK_W-1:0]             slot_m, set_m;
   logic [DPG*DATA_W+MASK_W-1:0]  mem [DEPTH];
   logic [PW-1:0]                 rd, wr;
   logic                          complete, empty, byp, push, pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
   endfunction

   assign in_ready = count < CNT_W'(DEPTH);
   assign empty    = count == '0;
   // valids are ignored while the FIFO is full
   assign vin      = {mvalid, dvalid} & {(DPG+1){in_ready}};
   assign complete = &(cap | vin);
   assign set_m    = vin[DPG] ? vmask : slot_m;
   for (genvar p = 0; p < DPG; p++)
      assign set_d[p*DATA_W +: DATA_W] = vin[p] ? vreg[p*DATA_W +: DATA_W] : slot_d[p*DATA_W +: DATA_W];

`ifdef OPC_BYPASS_EN
   assign byp = empty & complete & ~flush;
`else
   assign byp = 1'b0;
`endif

   assign out_valid              = ~empty | byp;
   assign {out_vreg, out_vmask}  = byp ? {set_d, set_m} : mem[rd];
   assign pop                    = ~empty & out_ready;
   // a bypassed set taken by the consumer never enters the FIFO
   assign push                   = complete & ~flush & ~(byp & out_ready);

   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         cap    <= '0;
         slot_d <= '0;
         slot_m <= '0;
         rd     <= '0;
         wr     <= '0;
         count  <= '0;
         err    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         cap   <= '0;
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         cap    <= complete ? '0 : cap | vin;
         slot_d <= set_d;
         slot_m <= set_m;
         err    <= err | (|(cap & vin));
         if (push) begin
            mem[wr] <= {set_d, set_m};
            wr      <= nxt(wr);
         end
         if (pop) rd <= nxt(rd);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
endmodule

// File: rtl/op_collector.sv
// op_collector: per-group operand collector between register-file read ports and issue
//   CLK/nRST     clock, async active-low reset
//   flush_i      drop all partial and queued sets in every group
//   dvalid_i/vreg_i    data operand captures, port p belongs to group p/DPG
//   mvalid_i/vmask_i   mask operand captures, one per group
//   in_ready_o   group accepts captures; out_valid_o/out_ready_i head-set handshake
//   out_vreg_o/out_vmask_o  head set; count_o FIFO occupancy; err_o sticky protocol error
//   OPC_BYPASS_EN  optional zero-latency presentation of a set completing into an empty FIFO
module op_collector
   import op_collector_pkg::*;
#(
   parameter  int NGROUPS = 2,
   parameter  int DPG     = OPC_DPG,
   parameter  int DEPTH   = OPC_DEPTH,
   parameter  int DATA_W  = $bits(vreg_t),
   parameter  int MASK_W  = $bits(vmask_t),
   localparam int CNT_W   = $clog2(DEPTH+1)
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic                          flush_i,
   input  logic [NGROUPS*DPG-1:0]        dvalid_i,
   input  logic [NGROUPS*DPG*DATA_W-1:0] vreg_i,
   input  logic [NGROUPS-1:0]            mvalid_i,
   input  logic [NGROUPS*MASK_W-1:0]     vmask_i,
   output logic [NGROUPS-1:0]            in_ready_o,
   output logic [NGROUPS-1:0]            out_valid_o,
   input  logic [NGROUPS-1:0]            out_ready_i,
   output logic [NGROUPS*DPG*DATA_W-1:0] out_vreg_o,
   output logic [NGROUPS*MASK_W-1:0]     out_vmask_o,
   output logic [NGROUPS*CNT_W-1:0]      count_o,
   output logic [NGROUPS-1:0]            err_o
);
   for (genvar g = 0; g < NGROUPS; g++) begin : grp
      op_group_collector #(.DPG(DPG), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W), .CNT_W(CNT_W)) u_grp (
         .CLK       (CLK),
         .nRST      (nRST),
         .flush     (flush_i),
         .dvalid    (dvalid_i[g*DPG +: DPG]),
         .vreg      (vreg_i[g*DPG*DATA_W +: DPG*DATA_W]),
         .mvalid    (mvalid_i[g]),
         .vmask     (vmask_i[g*MASK_W +: MASK_W]),
         .in_ready  (in_ready_o[g]),
         .out_valid (out_valid_o[g]),
         .out_ready (out_ready_i[g]),
         .out_vreg  (out_vreg_o[g*DPG*DATA_W +: DPG*DATA_W]),
         .out_vmask (out_vmask_o[g*MASK_W +: MASK_W]),
         .count     (count_o[g*CNT_W +: CNT_W]),
         .err       (err_o[g])
      );
   end
endmodule

// File: tb/tb_op_collector.sv
// tb_op_collector: directed scenarios plus random traffic against a queue-based reference model
module tb_op_collector;
   localparam int NG = 2, DPG = 2, DEPTH = 2, DATA_W = 512, MASK_W = 32;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int W = DPG*DATA_W;

   typedef struct {
      logic [W-1:0]      v;
      logic [MASK_W-1:0] m;
   } set_t;

   logic                   CLK = 0, nRST = 0, flush_i = 0;
   logic [NG*DPG-1:0]      dvalid_i = '0;
   logic [NG*W-1:0]        vreg_i = '0;
   logic [NG-1:0]          mvalid_i = '0, out_ready_i = '0;
   logic [NG*MASK_W-1:0]   vmask_i = '0;
   logic [NG-1:0]          in_ready_o, out_valid_o, err_o;
   logic [NG*W-1:0]        out_vreg_o;
   logic [NG*MASK_W-1:0]   out_vmask_o;
   logic [NG*CNT_W-1:0]    count_o;

   int total = 0, bad = 0;

   set_t              q [NG][$];
   logic [DATA_W-1:0] sd [NG][DPG];
   logic [MASK_W-1:0] sm [NG];
   bit                cd [NG][DPG];
   bit                cm [NG];
   bit                er [NG];

   op_collector #(.NGROUPS(NG), .DPG(DPG), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
      .CLK(CLK), .nRST(nRST), .flush_i(flush_i), .dvalid_i(dvalid_i), .vreg_i(vreg_i),
      .mvalid_i(mvalid_i), .vmask_i(vmask_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .out_vreg_o(out_vreg_o), .out_vmask_o(out_vmask_o),
      .count_o(count_o), .err_o(err_o)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int g, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s g%0d got=%0h exp=%0h", tag, g, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rnd_d();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic clr();
      dvalid_i = '0;
      mvalid_i = '0;
      flush_i  = 0;
   endtask

   task automatic put_d(input int g, input int p, input logic [DATA_W-1:0] v);
      dvalid_i[g*DPG+p] = 1'b1;
      vreg_i[(g*DPG+p)*DATA_W +: DATA_W] = v;
   endtask

   task automatic put_m(input int g, input logic [MASK_W-1:0] v);
      mvalid_i[g] = 1'b1;
      vmask_i[g*MASK_W +: MASK_W] = v;
   endtask

   task automatic model_reset();
      for (int g = 0; g < NG; g++) begin
         q[g].delete();
         sm[g] = '0;
         cm[g] = 0;
         er[g] = 0;
         for (int p = 0; p < DPG; p++) begin
            sd[g][p] = '0;
            cd[g][p] = 0;
         end
      end
   endtask

   task automatic chk_reset();
      for (int g = 0; g < NG; g++) begin
         chk("rst_valid", g, W'(out_valid_o[g]), '0);
         chk("rst_vreg", g, out_vreg_o[g*W +: W], '0);
         chk("rst_vmask", g, W'(out_vmask_o[g*MASK_W +: MASK_W]), '0);
         chk("rst_count", g, W'(count_o[g*CNT_W +: CNT_W]), '0);
         chk("rst_err", g, W'(err_o[g]), '0);
         chk("rst_ready", g, W'(in_ready_o[g]), W'(1));
      end
   endtask

   // inputs are already applied; check outputs mid-cycle, advance the model, then cross the edge
   task automatic step();
      #2;
      for (int g = 0; g < NG; g++) begin
         int   n;
         bit   rdy, comp, dup, byp, a, vis;
         set_t ns, h;
         n    = q[g].size();
         rdy  = n < DEPTH;
         comp = 1;
         dup  = 0;
         for (int p = 0; p < DPG; p++) begin
            a = rdy && dvalid_i[g*DPG+p];
            ns.v[p*DATA_W +: DATA_W] = a ? vreg_i[(g*DPG+p)*DATA_W +: DATA_W] : sd[g][p];
            comp = comp && (a || cd[g][p]);
            dup  = dup || (a && cd[g][p]);
         end
         a    = rdy && mvalid_i[g];
         ns.m = a ? vmask_i[g*MASK_W +: MASK_W] : sm[g];
         comp = comp && (a || cm[g]);
         dup  = dup || (a && cm[g]);
         byp  = 0;
`ifdef OPC_BYPASS_EN
         byp  = n == 0 && comp && !flush_i;
`endif
         vis = n != 0 || byp;
         chk("valid", g, W'(out_valid_o[g]), W'(vis));
         chk("count", g, W'(count_o[g*CNT_W +: CNT_W]), W'(n));
         chk("in_ready", g, W'(in_ready_o[g]), W'(rdy));
         chk("err", g, W'(err_o[g]), W'(er[g]));
         if (vis) begin
            h = byp ? ns : q[g][0];
            chk("vreg", g, out_vreg_o[g*W +: W], h.v);
            chk("vmask", g, W'(out_vmask_o[g*MASK_W +: MASK_W]), W'(h.m));
         end
         if (flush_i) begin
            q[g].delete();
            cm[g] = 0;
            for (int p = 0; p < DPG; p++) cd[g][p] = 0;
         end else begin
            er[g] = er[g] || dup;
            sm[g] = ns.m;
            cm[g] = !comp && (cm[g] || (rdy && mvalid_i[g]));
            for (int p = 0; p < DPG; p++) begin
               sd[g][p] = ns.v[p*DATA_W +: DATA_W];
               cd[g][p] = !comp && (cd[g][p] || (rdy && dvalid_i[g*DPG+p]));
            end
            if (n != 0 && out_ready_i[g]) void'(q[g].pop_front());
            if (comp && !(byp && out_ready_i[g])) q[g].push_back(ns);
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic full(input int g);
      for (int p = 0; p < DPG; p++) put_d(g, p, rnd_d());
      put_m(g, $urandom);
   endtask

   initial begin
      model_reset();
      #3 chk_reset();
      @(negedge CLK) nRST = 1;
      @(posedge CLK);
      #1;
      // aligned completion, then pop
      full(0); step();
      clr(); step();
      out_ready_i = 2'b01; step();
      out_ready_i = '0; step();
      // operands arriving over several cycles
      put_d(0, 0, rnd_d()); step();
      clr(); put_m(0, $urandom); step();
      clr(); put_d(0, 1, rnd_d()); step();
      clr(); step();
      out_ready_i = 2'b01; step(); step();
      // backpressure: third set ignored while full, then drain
      out_ready_i = '0;
      for (int i = 0; i < 3; i++) begin clr(); full(0); step(); end
      clr(); step();
      out_ready_i = 2'b01;
      for (int i = 0; i < 3; i++) step();
      // duplicate capture sets sticky err
      out_ready_i = '0;
      put_d(0, 0, rnd_d()); step();
      clr(); put_d(0, 0, rnd_d()); step();
      clr(); put_d(0, 1, rnd_d()); put_m(0, $urandom); step();
      clr(); out_ready_i = 2'b01; step(); step();
      full(0); step(); clr(); step(); step();
      // flush with a queued g0 set and a partial g1 set
      out_ready_i = '0;
      full(0); step();
      clr(); put_d(1, 0, rnd_d()); step();
      clr(); flush_i = 1; put_d(1, 1, rnd_d()); put_m(1, $urandom); step();
      clr(); step();
      put_d(1, 1, rnd_d()); put_m(1, $urandom); step();
      clr(); step();
      // single-cycle completion with consumer ready
      out_ready_i = 2'b10; full(1); step();
      clr(); step(); step();
      // random traffic
      for (int i = 0; i < 400; i++) begin
         clr();
         for (int g = 0; g < NG; g++) begin
            for (int p = 0; p < DPG; p++) if ($urandom_range(0, 9) < 4) put_d(g, p, rnd_d());
            if ($urandom_range(0, 9) < 4) put_m(g, $urandom);
            out_ready_i[g] = $urandom_range(0, 1) == 1;
         end
         flush_i = $urandom_range(0, 31) == 0;
         step();
      end
      // asynchronous reset in the middle of traffic
      clr(); full(0); full(1); out_ready_i = '0;
      nRST = 0;
      #1 chk_reset();
      model_reset();
      clr();
      @(negedge CLK) nRST = 1;
      @(posedge CLK);
      #1;
      full(1); step();
      clr(); out_ready_i = 2'b10; step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
